// File: rtl/vga_scan_generator_if.sv
// vga_scan_generator_if
// Bundles the sprite-side coordinate/color exchange and the VGA DAC outputs.
//   color       : {R,G,B} from the sprite combiner, one cycle behind xvga/yvga
//   xvga, yvga  : downscaled sprite coordinates (0 outside the visible region)
//   VGA_HS/VS   : active-low syncs
//   VGA_BLANK_N : high while the output pixel is visible
//   VGA_R/G/B   : 8-bit DAC channel values
//   frame_start : one-cycle pulse on output pixel (0,0)
// master: the scan generator; slave: the combiner / display side.
interface vga_scan_generator_if;
  logic [2:0] color;
  logic [7:0] xvga;
  logic [6:0] yvga;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       frame_start;

  modport master (
    input  color,
    output xvga, yvga, VGA_HS, VGA_VS, VGA_BLANK_N,
    output VGA_R, VGA_G, VGA_B, frame_start
  );

  modport slave (
    output color,
    input  xvga, yvga, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  VGA_R, VGA_G, VGA_B, frame_start
  );
endinterface

// File: rtl/vga_scan_generator.sv
// vga_scan_generator
// Free-running VGA raster counter with a two-stage output pipeline. The
// sprite coordinates leave combinationally from the counters; the combiner
// answers with a color one cycle later, and syncs/blank/color all emerge
// together two cycles after the counter state that produced them.
// Ports:
//   VGA_CLK : pixel clock, rising edge
//   reset_n : asynchronous active-low reset
//   vga     : vga_scan_generator_if.master (color in, coordinates/VGA out)
module vga_scan_generator #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                        VGA_CLK,
  input  logic                        reset_n,
  vga_scan_generator_if.master        vga
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       h_wrap;

  assign h_wrap = (hcount == H_LAST);

  // vcount advances only as hcount wraps, so both return to 0 on one edge.
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_wrap ? 10'd0 : hcount + 10'd1;
      if (h_wrap)
        vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end
  end

  // ---- stage p0: combinational decode of the counters ----
  logic vld_p0, hs_p0, vs_p0, sof_p0;

  assign vld_p0 = (hcount < H_VIS) && (vcount < V_VIS);
  assign hs_p0  = !((hcount >= HS_START) && (hcount < HS_END));
  assign vs_p0  = !((vcount >= VS_START) && (vcount < VS_END));
  assign sof_p0 = (hcount == 10'd0) && (vcount == 10'd0);

  assign vga.xvga = vld_p0 ? 8'(hcount >> SCALE_SHIFT) : 8'd0;
  assign vga.yvga = vld_p0 ? 7'(vcount >> SCALE_SHIFT) : 7'd0;

  // ---- stage p1: combiner is resolving color for these coordinates ----
  logic vld_p1, hs_p1, vs_p1, sof_p1;

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      sof_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      sof_p1 <= sof_p0;
    end
  end

  // ---- stage p2: registered outputs; color captured here, blank-gated ----
  logic       vld_p2, hs_p2, vs_p2, sof_p2;
  logic [7:0] r_p2, g_p2, b_p2;

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      sof_p2 <= 1'b0;
      r_p2   <= 8'h00;
      g_p2   <= 8'h00;
      b_p2   <= 8'h00;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      sof_p2 <= sof_p1;
      r_p2   <= vld_p1 ? {8{vga.color[2]}} : 8'h00;
      g_p2   <= vld_p1 ? {8{vga.color[1]}} : 8'h00;
      b_p2   <= vld_p1 ? {8{vga.color[0]}} : 8'h00;
    end
  end

  assign vga.VGA_HS      = hs_p2;
  assign vga.VGA_VS      = vs_p2;
  assign vga.VGA_BLANK_N = vld_p2;
  assign vga.frame_start = sof_p2;
  assign vga.VGA_R       = r_p2;
  assign vga.VGA_G       = g_p2;
  assign vga.VGA_B       = b_p2;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator
// Directed bench. Instance A uses the default 640x480 timing for line-level
// timing, coordinates, color path and mid-line reset; instance B uses a tiny
// raster (24 x 17) so whole frames fit in a short run.
module tb_vga_scan_generator;

  logic VGA_CLK = 1'b0;
  logic rst_a_n, rst_b_n;
  logic mode;
  logic [7:0] x_d;

  always #5 VGA_CLK = ~VGA_CLK;

  vga_scan_generator_if ifa ();
  vga_scan_generator_if ifb ();

  vga_scan_generator dut_a (
    .VGA_CLK (VGA_CLK),
    .reset_n (rst_a_n),
    .vga     (ifa)
  );

  vga_scan_generator #(
    .H_VISIBLE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_VISIBLE (12), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SCALE_SHIFT (2)
  ) dut_b (
    .VGA_CLK (VGA_CLK),
    .reset_n (rst_b_n),
    .vga     (ifb)
  );

  // Combiner model: color is a function of xvga seen one cycle earlier.
  always @(posedge VGA_CLK) x_d <= ifa.xvga;
  assign ifa.color = mode ? x_d[2:0] : 3'b101;
  assign ifb.color = 3'b101;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge VGA_CLK);
    #1;
  endtask

  int n, col;
  int fs_cnt, fs_first, fs_1, fs_2;
  int nf, nr, fall0, fall1, rise0, rise1;
  int low_cnt, vs_low, early_low;
  int pix_bad, mdl_bad;
  logic prev_hs, prev_vs;
  logic exp_vis;
  logic [7:0] er, eg, eb;

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    mode    = 1'b0;
    repeat (3) step();

    check("rst_hs",    ifa.VGA_HS, 1);
    check("rst_vs",    ifa.VGA_VS, 1);
    check("rst_blank", ifa.VGA_BLANK_N, 0);
    check("rst_rgb",   {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}, 0);
    check("rst_fs",    ifa.frame_start, 0);
    check("rst_xy",    {ifa.xvga, ifa.yvga}, 0);

    // ---------- instance A: three lines after release ----------
    rst_a_n = 1'b1;
    fs_cnt = 0; fs_first = -1; nf = 0; nr = 0; fall0 = -1; fall1 = -1;
    rise0 = -1; rise1 = -1; low_cnt = 0; vs_low = 0; pix_bad = 0; mdl_bad = 0;
    prev_hs = 1'b1;
    for (int c = 0; c <= 2521; c++) begin
      if (c > 0) step();
      if (c == 1000) mode = 1'b1;
      if (ifa.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c;
      end
      if (prev_hs && !ifa.VGA_HS) begin
        if (nf == 0) fall0 = c; else if (nf == 1) fall1 = c;
        nf++;
      end
      if (!prev_hs && ifa.VGA_HS) begin
        if (nr == 0) rise0 = c; else if (nr == 1) rise1 = c;
        nr++;
      end
      prev_hs = ifa.VGA_HS;
      if (!ifa.VGA_HS) low_cnt++;
      if (!ifa.VGA_VS) vs_low++;

      if (c >= 2 && c <= 801) begin
        n = c - 2;
        exp_vis = (n < 640);
        if (ifa.VGA_BLANK_N !== exp_vis ||
            ifa.VGA_R !== (exp_vis ? 8'hFF : 8'h00) ||
            ifa.VGA_G !== 8'h00 ||
            ifa.VGA_B !== (exp_vis ? 8'hFF : 8'h00))
          pix_bad++;
      end
      if (c >= 1602 && c <= 2401) begin
        n = c - 1602;
        col = (n < 640) ? ((n >> 2) & 7) : 0;
        er = col[2] ? 8'hFF : 8'h00;
        eg = col[1] ? 8'hFF : 8'h00;
        eb = col[0] ? 8'hFF : 8'h00;
        if (ifa.VGA_R !== er || ifa.VGA_G !== eg || ifa.VGA_B !== eb ||
            ifa.VGA_BLANK_N !== (n < 640))
          mdl_bad++;
      end

      if (c == 2) begin
        check("fs_at_2",    ifa.frame_start, 1);
        check("blank_at_2", ifa.VGA_BLANK_N, 1);
        check("r_at_2",     ifa.VGA_R, 8'hFF);
      end
      if (c == 642) check("blank_px640", ifa.VGA_BLANK_N, 0);
      if (c == 639) check("x_h639", ifa.xvga, 159);
      if (c == 640) check("x_h640", ifa.xvga, 0);
      if (c >= 4 && c <= 7) check("x_h4to7", ifa.xvga, 1);
      if (c == 805) check("y_v1", ifa.yvga, 0);
      if (c == 1439) check("x_l1_h639", ifa.xvga, 159);
      if (c == 1609) check("mdl_px7", {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}, 24'h0000FF);
      if (c == 2241) check("mdl_px639", {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}, 24'hFFFFFF);
    end
    check("fs_count",  fs_cnt, 1);
    check("fs_first",  fs_first, 2);
    check("hs_fall0",  fall0, 658);
    check("hs_rise0",  rise0, 754);
    check("hs_fall1",  fall1, 1458);
    check("hs_rise1",  rise1, 1554);
    check("hs_lowcnt", low_cnt, 288);
    check("vs_quiet",  vs_low, 0);
    check("pix_101",   pix_bad, 0);
    check("pix_model", mdl_bad, 0);

    // ---------- instance A: asynchronous mid-line reset ----------
    check("pre_rst_rgb", {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}, 24'hFF00FF);
    check("pre_rst_x",   ifa.xvga, 30);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("arst_rgb",   {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}, 0);
    check("arst_blank", ifa.VGA_BLANK_N, 0);
    check("arst_x",     ifa.xvga, 0);
    check("arst_sync",  {ifa.VGA_HS, ifa.VGA_VS, ifa.frame_start}, 3'b110);
    repeat (3) step();
    rst_a_n = 1'b1;
    fs_cnt = 0; fs_first = -1; fall0 = -1; rise0 = -1; nf = 0; nr = 0;
    early_low = 0; vs_low = 0; prev_hs = 1'b1;
    for (int c = 0; c <= 760; c++) begin
      if (c > 0) step();
      if (c == 1) check("rel_x_h1", ifa.xvga, 0);
      if (ifa.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c;
      end
      if (prev_hs && !ifa.VGA_HS && nf == 0) begin fall0 = c; nf++; end
      if (!prev_hs && ifa.VGA_HS && nr == 0) begin rise0 = c; nr++; end
      prev_hs = ifa.VGA_HS;
      if (!ifa.VGA_HS && c < 658) early_low++;
      if (!ifa.VGA_VS) vs_low++;
    end
    check("rel_fs_first", fs_first, 2);
    check("rel_fs_count", fs_cnt, 1);
    check("rel_hs_fall",  fall0, 658);
    check("rel_hs_rise",  rise0, 754);
    check("rel_no_spur",  early_low, 0);
    check("rel_vs_quiet", vs_low, 0);

    // ---------- instance B: two small frames ----------
    rst_b_n = 1'b1;
    fs_cnt = 0; fs_first = -1; fs_1 = -1; fs_2 = -1;
    nf = 0; nr = 0; fall0 = -1; fall1 = -1; rise0 = -1; rise1 = -1;
    low_cnt = 0; vs_low = 0; prev_vs = 1'b1;
    for (int c = 0; c <= 830; c++) begin
      if (c > 0) step();
      if (ifb.frame_start) begin
        if (fs_cnt == 0) fs_first = c;
        else if (fs_cnt == 1) fs_1 = c;
        else if (fs_cnt == 2) fs_2 = c;
        fs_cnt++;
      end
      if (prev_vs && !ifb.VGA_VS) begin
        if (nf == 0) fall0 = c; else if (nf == 1) fall1 = c;
        nf++;
      end
      if (!prev_vs && ifb.VGA_VS) begin
        if (nr == 0) rise0 = c; else if (nr == 1) rise1 = c;
        nr++;
      end
      prev_vs = ifb.VGA_VS;
      if (!ifb.VGA_VS) begin
        vs_low++;
        if (c < 410) low_cnt++;
      end
      if (c == 264) check("b_y_v11",  ifb.yvga, 2);
      if (c == 288) check("b_y_v12",  ifb.yvga, 0);
      if (c == 279) check("b_x_h15",  ifb.xvga, 3);
      if (c == 280) check("b_x_h16",  ifb.xvga, 0);
      if (c == 271) check("b_vis_px", {ifb.VGA_BLANK_N, ifb.VGA_R}, 9'h1FF);
      if (c == 317) check("b_vblank", {ifb.VGA_BLANK_N, ifb.VGA_R}, 9'h000);
    end
    check("b_fs_first",   fs_first, 2);
    check("b_fs_second",  fs_1, 410);
    check("b_fs_period",  fs_2 - fs_1, 408);
    check("b_vs_fall0",   fall0, 314);
    check("b_vs_rise0",   rise0, 362);
    check("b_vs_fall1",   fall1, 722);
    check("b_vs_rise1",   rise1, 770);
    check("b_vs_frame0",  low_cnt, 48);
    check("b_vs_total",   vs_low, 96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_generator.md
VGA_SCAN_GENERATOR -- requirements
Module: vga_scan_generator

Interface
REQ-001 SHALL provide parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL provide parameters H_FP 16, H_SYNC 96, H_BP 48, which are the horizontal porch and sync widths in clocks.
REQ-003 SHALL provide parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33, which are the vertical porch and sync widths in lines.
REQ-004 SHALL provide parameter SCALE_SHIFT, default 2, which is the log2 downscale from screen pixels to sprite coordinates.
REQ-005 VGA_CLK  input  1  pixel clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 color  input  3  {R,G,B} pixel from the sprite combiner, valid one cycle after the matching xvga/yvga.
REQ-008 xvga  output  8  horizontal sprite coordinate (hcount >> SCALE_SHIFT).
REQ-009 yvga  output  7  vertical sprite coordinate (vcount >> SCALE_SHIFT).
REQ-010 VGA_HS  output  1  horizontal sync, active low.
REQ-011 VGA_VS  output  1  vertical sync, active low.
REQ-012 VGA_BLANK_N  output  1  high during the visible region.
REQ-013 VGA_R, VGA_G, VGA_B  output  8 each  DAC channel values.
REQ-014 frame_start  output  1  one-cycle pulse marking output pixel (0,0).

Function
REQ-015 hcount (10 bit) SHALL increment every clock over 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800), and SHALL wrap to 0.
REQ-016 vcount (10 bit) SHALL increment only on the hcount wrap, over 0..V_TOTAL-1 (525), and SHALL wrap to 0 on the same edge that hcount wraps from 799.
REQ-017 Stage 0 signals SHALL be combinational from the counters.
- visible = hcount < H_VISIBLE && vcount < V_VISIBLE.
- hs_raw low for H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (656..751).
- vs_raw low for V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (490..491).
REQ-018 While visible, xvga/yvga SHALL be driven combinationally from the counters, truncated to port width; while not visible they SHALL be 0.
REQ-019 visible, hs_raw, vs_raw and the (0,0) condition SHALL pass through a 2-stage register pipeline, so the outputs for the counter state of cycle t appear during cycle t+2.
REQ-020 color SHALL be registered on the edge ending cycle t+1, so it appears during cycle t+2, aligned with the matching syncs.
REQ-021 VGA_R SHALL be {8{color_q[2]}}, VGA_G {8{color_q[1]}} and VGA_B {8{color_q[0]}}, each forced to 8'h00 when the delayed visible is 0.
REQ-022 frame_start SHALL be high for exactly one cycle per frame, coincident with the first visible output pixel; its period SHALL be 420000 clocks.
REQ-023 There SHALL be no input handshake; color is sampled unconditionally every cycle.
REQ-024 Sync widths SHALL be exact: VGA_HS low 96 clocks per line; VGA_VS low 1600 clocks per frame, with edges aligned to the delayed hcount = 0 of lines 490 and 492.

Reset
REQ-025 While reset_n = 0, hcount, vcount and all pipeline registers SHALL be 0 / inactive, independent of VGA_CLK.
REQ-026 Reset values: VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, VGA_R/G/B = 0, frame_start = 0, xvga = 0, yvga = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately.
REQ-028 On reset release, counting SHALL restart at (0,0): the first rising edge after release advances hcount to 1.
REQ-029 The pipeline SHALL refill without spurious sync pulses.
REQ-030 The first frame_start after reset SHALL occur 2 cycles after release.

Verification
REQ-031 Release reset, then count clocks: frame_start at cycle 2; VGA_HS falls at cycle 658 and rises at cycle 754; the pattern repeats every 800 clocks.
REQ-032 Run two full frames: VGA_VS low for exactly 1600 consecutive clocks per frame, starting at output line 490; frame_start interval = 420000.
REQ-033 Check coordinates:
- hcount 639 -> xvga 159; hcount 640 -> xvga 0.
- vcount 479 -> yvga 119; vcount 480 -> yvga 0.
- hcount 4..7 -> xvga 1.
REQ-034 Hold color = 3'b101: visible outputs R = 255, G = 0, B = 255; every blanked cycle outputs 0/0/0 with VGA_BLANK_N = 0.
REQ-035 Drive color = a per-cycle function of xvga delayed by 1 cycle (combiner model): output pixel n SHALL carry the color for xvga = n >> 2, with no off-by-one.
REQ-036 Assert reset_n low for 3 cycles mid-line at vcount 100: outputs take reset values asynchronously; after release, timing matches REQ-031 exactly.
